// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute/writeback stage.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam logic [1:0] R1_IDX = 2'd1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_SHL = 3'd4,
    OP_MUL = 3'd5,
    OP_MOV = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MUL_ITER = 3'd2,
    ST_WB_LO    = 3'd3,
    ST_WB_HI    = 3'd4
  } exec_state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
module shift_add_mul #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  busy,
  output logic                  last
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                busy_q;

  // Load operands on request, then add/shift once per cycle until all bits are consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_W'(DATA_W - 1)) busy_q <= 1'b0;
    end
  end

  assign product = acc;
  assign busy    = busy_q;
  assign last    = busy_q && (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/exec_writeback.sv
// Execute-and-writeback stage feeding the 4x8 register file's single write port.
module exec_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        rd,
  input  logic [1:0]        rs,
  output logic              ready,
  output logic              done,
  output logic [1:0]        rf_r_a,
  output logic [1:0]        rf_r_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              wb_en,
  output logic [1:0]        wb_reg,
  output logic [DATA_W-1:0] wb_value,
  output logic              zero,
  output logic              carry
);

  exec_state_e         state;
  op_e                 op_q;
  logic [1:0]          rd_q, rs_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                zero_q, carry_q;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [DATA_W:0]     alu_wide;

  logic [2*DATA_W-1:0] product;
  logic                mul_busy, mul_last;
  logic                mul_load;

  assign mul_load = (state == ST_IDLE) && start && (op_e'(op) == OP_MUL);

  shift_add_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .a       (rf_data_a),
    .b       (rf_data_b),
    .product (product),
    .busy    (mul_busy),
    .last    (mul_last)
  );

  // Single-cycle ALU on the latched operands; MUL and NOP produce no result here.
  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = carry_q;
    case (op_q)
      OP_ADD: begin
        alu_wide  = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q >= b_q);
      end
      OP_AND: begin
        alu_res   = a_q & b_q;
        alu_carry = 1'b0;
      end
      OP_XOR: begin
        alu_res   = a_q ^ b_q;
        alu_carry = 1'b0;
      end
      OP_SHL: begin
        alu_wide  = {1'b0, a_q} << b_q[2:0];
        alu_res   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_MOV: begin
        alu_res   = b_q;
        alu_carry = 1'b0;
      end
      default: begin
        alu_res   = '0;
        alu_carry = carry_q;
      end
    endcase
  end

  // Read indices follow the decoder while idle, the latched copies otherwise.
  always_comb begin
    rf_r_a = rd_q;
    rf_r_b = rs_q;
    if (state == ST_IDLE) begin
      rf_r_a = rd;
      rf_r_b = rs;
    end
  end

  // Moore decode of handshake and write-port outputs from state and latches.
  always_comb begin
    ready    = (state == ST_IDLE);
    done     = (state == ST_EXEC) || (state == ST_WB_HI);
    wb_en    = 1'b0;
    wb_reg   = '0;
    wb_value = '0;
    case (state)
      ST_EXEC: begin
        wb_en    = (op_q != OP_NOP);
        wb_reg   = rd_q;
        wb_value = alu_res;
      end
      ST_WB_LO: begin
        wb_en    = 1'b1;
        wb_reg   = rd_q;
        wb_value = product[DATA_W-1:0];
      end
      ST_WB_HI: begin
        wb_en    = 1'b1;
        wb_reg   = R1_IDX;
        wb_value = product[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  // Control FSM: accept and latch operands, sequence MUL, update flags on the retiring edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      rs_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            rd_q  <= rd;
            rs_q  <= rs;
            a_q   <= rf_data_a;
            b_q   <= rf_data_b;
            state <= (op_e'(op) == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q != OP_NOP) begin
            zero_q  <= (alu_res == '0);
            carry_q <= alu_carry;
          end
          state <= ST_IDLE;
        end
        ST_MUL_ITER: begin
          if (mul_last) state <= ST_WB_LO;
        end
        ST_WB_LO: begin
          state <= ST_WB_HI;
        end
        ST_WB_HI: begin
          zero_q  <= (product == '0);
          carry_q <= (product[2*DATA_W-1:DATA_W] != '0);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_exec_writeback.sv
// Scoreboard bench for exec_writeback with a behavioural register file.
module tb_exec_writeback;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [1:0] rd = 2'd0, rs = 2'd0;
  logic       ready, done, wb_en, zero, carry;
  logic [1:0] rf_r_a, rf_r_b, wb_reg;
  logic [7:0] rf_data_a, rf_data_b, wb_value;

  logic [7:0] rf [4];
  logic [7:0] mdl [4];
  bit         mz = 1'b0, mc = 1'b0;

  logic       pl_en = 1'b0;
  logic [1:0] pl_idx = 2'd0;
  logic [7:0] pl_val = 8'd0;

  logic [9:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;

  exec_writeback #(.DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rd        (rd),
    .rs        (rs),
    .ready     (ready),
    .done      (done),
    .rf_r_a    (rf_r_a),
    .rf_r_b    (rf_r_b),
    .rf_data_a (rf_data_a),
    .rf_data_b (rf_data_b),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_value  (wb_value),
    .zero      (zero),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  assign rf_data_a = rf[rf_r_a];
  assign rf_data_b = rf[rf_r_b];

  // Register file: DUT write port, plus a preload path used only while the stage is idle.
  always @(posedge clk) begin
    if (wb_en && !reset) rf[wb_reg] <= wb_value;
    else if (pl_en)      rf[pl_idx] <= pl_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write seen on the port must match the next expected write.
  always @(negedge clk) begin
    if (!reset && wb_en) begin
      n_wr++;
      if (exp_q.size() == 0) check("spurious_wb", {31'd0, wb_en}, 32'd0);
      else check("wb_reg_value", {22'd0, wb_reg, wb_value}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic set_reg(input logic [1:0] idx, input logic [7:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    mdl[idx] = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s, input bit poke);
    logic [7:0]  a, b, res;
    logic [8:0]  wide;
    logic [15:0] prod;
    int sh, exp_lat, nwr, cyc, busy_cyc, guard, wr0;
    bit seen, exp_wen;
    a = mdl[d];
    b = mdl[s];
    exp_lat = (o == 3'd5) ? 10 : 1;
    exp_wen = (o != 3'd7);
    nwr = (o == 3'd7) ? 0 : ((o == 3'd5) ? 2 : 1);

    @(negedge clk);
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", {31'd0, ready}, 32'd1);

    case (o)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[7:0]; mc = wide[8]; end
      3'd1: begin res = a - b; mc = (a >= b); end
      3'd2: begin res = a & b; mc = 1'b0; end
      3'd3: begin res = a ^ b; mc = 1'b0; end
      3'd4: begin
        sh  = int'(b[2:0]);
        res = a << sh;
        mc  = (sh == 0) ? 1'b0 : a[8 - sh];
      end
      3'd6: begin res = b; mc = 1'b0; end
      default: res = 8'd0;
    endcase
    if (o == 3'd5) begin
      prod = 16'(a) * 16'(b);
      exp_q.push_back({d, prod[7:0]});
      exp_q.push_back({2'd1, prod[15:8]});
      mdl[d] = prod[7:0];
      mdl[1] = prod[15:8];
      mz = (prod == 16'd0);
      mc = (prod[15:8] != 8'd0);
    end else if (o != 3'd7) begin
      exp_q.push_back({d, res});
      mdl[d] = res;
      mz = (res == 8'd0);
    end

    wr0 = n_wr;
    start = 1'b1;
    op = o;
    rd = d;
    rs = s;
    cyc = 0;
    busy_cyc = 0;
    seen = 1'b0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == 3) begin start = 1'b1; op = 3'd0; end
      if (poke && cyc == 4) start = 1'b0;
      if (!ready) busy_cyc++;
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", cyc, exp_lat);
    check("busy_cycles", busy_cyc, exp_lat);
    check("done_wb_en", {31'd0, wb_en}, {31'd0, exp_wen});
    @(negedge clk);
    check("zero", {31'd0, zero}, {31'd0, mz});
    check("carry", {31'd0, carry}, {31'd0, mc});
    check("ready_after", {31'd0, ready}, 32'd1);
    check("write_count", n_wr - wr0, nwr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wb_en", {31'd0, wb_en}, 32'd0);
    check("rst_wb_reg", {30'd0, wb_reg}, 32'd0);
    check("rst_wb_value", {24'd0, wb_value}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_reg(2'(i), 8'd0);

    // ADD with carry out
    set_reg(2'd0, 8'hF0);
    set_reg(2'd2, 8'h20);
    run_op(3'd0, 2'd0, 2'd2, 1'b0);

    // SUB equal, then SUB with borrow
    set_reg(2'd3, 8'h05);
    set_reg(2'd2, 8'h05);
    run_op(3'd1, 2'd3, 2'd2, 1'b0);
    set_reg(2'd3, 8'h04);
    run_op(3'd1, 2'd3, 2'd2, 1'b0);

    // AND / XOR / MOV
    set_reg(2'd1, 8'h3C);
    run_op(3'd2, 2'd1, 2'd3, 1'b0);
    run_op(3'd3, 2'd3, 2'd2, 1'b0);
    run_op(3'd6, 2'd1, 2'd0, 1'b0);

    // MUL with a stray start during iterations
    set_reg(2'd0, 8'hC8);
    set_reg(2'd2, 8'h0A);
    run_op(3'd5, 2'd0, 2'd2, 1'b1);

    // MUL into r1: high byte overwrites low byte
    set_reg(2'd1, 8'h11);
    set_reg(2'd3, 8'h22);
    run_op(3'd5, 2'd1, 2'd3, 1'b0);

    // SHL by 1, then by 0
    set_reg(2'd0, 8'h81);
    set_reg(2'd3, 8'h01);
    run_op(3'd4, 2'd0, 2'd3, 1'b0);
    set_reg(2'd3, 8'h00);
    run_op(3'd4, 2'd0, 2'd3, 1'b0);

    // NOP after a carry-setting op keeps flags
    set_reg(2'd2, 8'hFF);
    run_op(3'd0, 2'd2, 2'd2, 1'b0);
    run_op(3'd7, 2'd0, 2'd1, 1'b0);

    // Random mix
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) set_reg(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during MUL iteration 4: nothing written, flags cleared
    set_reg(2'd0, 8'hFF);
    run_op(3'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    wr0 = n_wr;
    start = 1'b1;
    op = 3'd5;
    rd = 2'd0;
    rs = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid_wb_en", {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mz = 1'b0;
    mc = 1'b0;
    exp_q.delete();
    #1;
    check("rstmid_ready", {31'd0, ready}, 32'd1);
    check("rstmid_zero", {31'd0, zero}, 32'd0);
    check("rstmid_carry", {31'd0, carry}, 32'd0);
    repeat (12) @(negedge clk);
    check("rstmid_no_write", n_wr - wr0, 0);
    check("rstmid_idle", {31'd0, ready}, 32'd1);

    // Normal operation resumes after the aborted MUL
    run_op(3'd3, 2'd0, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_writeback.md
# exec_writeback

Execute-and-writeback stage that sits directly upstream of the 4×8-bit register file. It reads two source registers through the register file's asynchronous read ports, computes an 8-bit ALU result, and drives the file's single write port. Single-cycle ops retire in one cycle. `MUL` runs an 8-iteration shift-add sequence, then spends two writeback cycles storing the low byte to `rd` and the high byte to r1. The decoder holds instructions off with `ready`.

## Interface
Parameters:
- `DATA_W`, 8, datapath width; only 8 is supported.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: instruction valid; accepted only when `ready`=1.
- `op` in 3: opcode (see Operation).
- `rd` in 2: destination register, also operand A.
- `rs` in 2: operand B register.
- `ready` out 1: stage idle; 1 in IDLE only.
- `done` out 1: 1-cycle pulse on the instruction's final writeback cycle.
- `rf_r_a` out 2: register-file read index A.
- `rf_r_b` out 2: register-file read index B.
- `rf_data_a` in 8: register-file read data A.
- `rf_data_b` in 8: register-file read data B.
- `wb_en` out 1: register-file write enable.
- `wb_reg` out 2: register-file write index.
- `wb_value` out 8: register-file write data.
- `zero` out 1: registered flag, set when the last written result is 0.
- `carry` out 1: registered carry/no-borrow flag.

## Operation
- Opcodes:
  - 0 `ADD`: a+b, carry = bit 8.
  - 1 `SUB`: a−b, carry = 1 if a≥b unsigned.
  - 2 `AND`.
  - 3 `XOR`.
  - 4 `SHL`: a << b[2:0], carry = last bit shifted out, 0 if the shift amount is 0.
  - 5 `MUL`: unsigned 8×8→16.
  - 6 `MOV`: rd ← b.
  - 7 `NOP`: no write, `done` still pulses.
- `AND`, `XOR` and `MOV` clear `carry`.
- `NOP` leaves both flags unchanged.
- Read indices:
  - In IDLE, `rf_r_a`=`rd` and `rf_r_b`=`rs`, passed straight through from the inputs.
  - In all other states they come from the latched copies.
- States: IDLE, EXEC, MUL_ITER, WB_LO, WB_HI.
  - IDLE: on `start`, latch op/rd/rs plus `rf_data_a`/`rf_data_b`.
    - Go to EXEC for non-`MUL` ops.
    - Go to MUL_ITER (iteration counter=0) for `MUL`.
  - EXEC: `wb_en`=1 (0 for `NOP`), `wb_reg`=rd, `wb_value`=result, `done`=1; go to IDLE.
  - MUL_ITER: one multiplier bit per cycle, LSB first. After the 8th iteration go to WB_LO.
  - WB_LO: write the product's low byte to rd; go to WB_HI.
  - WB_HI: write the product's high byte to r1, `done`=1; go to IDLE.
- `MUL` flags, updated in WB_HI:
  - `zero` = (product == 0).
  - `carry` = (high byte ≠ 0).
- If `MUL` has rd=1, WB_HI overwrites the low byte; the final r1 value is the high byte.
- Operands are latched at acceptance. The stage never re-reads the register file mid-operation, so its own WB_LO write cannot corrupt the `MUL` operands.
- `start` while `ready`=0 is ignored and not queued; the decoder must hold the instruction.
- All arithmetic is unsigned mod 2^8, except the `MUL` accumulator, which is 16 bits.

## Timing
- Reset values:
  - State IDLE.
  - `ready`=1.
  - `done`=0, `wb_en`=0, `wb_reg`=0, `wb_value`=0.
  - `zero`=0, `carry`=0.
  - Latches and the iteration counter = 0.
- Write outputs (`wb_en`, `wb_reg`, `wb_value`) and `done` are Moore outputs decoded from state and latched registers. The register file commits the write on the same clk edge that leaves the state.
- Latency, counting the acceptance edge as edge 0:
  - Single-cycle op: written on edge 1.
  - `MUL`: low byte written on edge 9, high byte on edge 10.
- Throughput: back-to-back single-cycle ops issue every 2 cycles (accept, execute).
- Reset mid-operation: immediate return to IDLE. A pending writeback is dropped and flags are cleared.

## Structure
- Shared package `cpu_pkg`: `op_e` opcode enum, `exec_state_e` state enum, `DATA_W`, `R1_IDX`=2'd1.
- Sub-module `shift_add_mul`:
  - Inputs: clk, reset, load, a, b.
  - Outputs: product[15:0], busy, last.
  - Owns the 16-bit accumulator and the 3-bit counter.
  - `last` is high during the 8th iteration.
- Top level holds the FSM, ALU case statement, flag registers and read-index mux.

## Test plan
- Reset mid-`MUL` (assert at iteration 4) → no `wb_en` is seen, `ready`=1 the next cycle, flags 0.
- r0=0xF0, r2=0x20, `ADD` rd=0 rs=2 → edge 1: `wb_en`=1, `wb_reg`=0, `wb_value`=0x10, `carry`=1, `zero`=0, `done`=1.
- r3=0x05, r2=0x05, `SUB` rd=3 rs=2 → `wb_value`=0x00, `zero`=1, `carry`=1. Then r3=0x04, `SUB` → `wb_value`=0xFF, `carry`=0.
- r0=0xC8, r2=0x0A, `MUL` rd=0 rs=2 → `ready`=0 for 10 cycles.
  - Edge 9: r0 ← 0xD0.
  - Edge 10: r1 ← 0x07, `carry`=1, `done` pulse.
- `start` pulsed during `MUL` iterations → ignored; exactly 2 writes occur.
- r0=0x81, r3=0x01, `SHL` rd=0 rs=3 → `wb_value`=0x02, `carry`=1. Then `SHL` by 0 → value unchanged, `carry`=0.
- `NOP` → `done`=1 with `wb_en`=0.
